// File: rtl/boot_loader.sv
// Byte-stream program loader: parses MAGIC/LEN/words/checksum frames, writes the
// instruction ROM and releases the CPU reset only after a verified image.
module boot_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [15:0]           rom_wdata,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  load_error
);

  // Largest legal frame length (full ROM depth); assumes ADDR_WIDTH <= 16.
  localparam logic [16:0] MaxLen = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StDataHi, StDataLo, StCheck, StDone, StError
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [16:0]             count_q, count_d;
  logic [7:0]              csum_q, csum_d;
  logic [7:0]              hi_q, hi_d;
  logic                    rom_we_q, rom_we_d;
  logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
  logic [15:0]             rom_wdata_q, rom_wdata_d;
  logic                    cpu_rst_q, cpu_rst_d;
  logic                    load_done_q, load_done_d;
  logic                    load_error_q, load_error_d;
  logic                    accept;

  assign rx_ready   = (state_q != StDone);
  assign accept     = rx_valid && rx_ready;
  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_wdata  = rom_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    count_d      = count_q;
    csum_d       = csum_q;
    hi_d         = hi_q;
    rom_we_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    rom_wdata_d  = rom_wdata_q;
    cpu_rst_d    = cpu_rst_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;

    if (accept) begin
      case (state_q)
        StIdle, StError: begin
          if (rx_data == MAGIC) begin
            state_d      = StLenHi;
            csum_d       = 8'h00;
            rom_addr_d   = '0;
            count_d      = '0;
            load_error_d = 1'b0;
          end
        end
        StLenHi: begin
          len_d   = {rx_data, len_q[7:0]};
          state_d = StLenLo;
        end
        StLenLo: begin
          len_d = {len_q[15:8], rx_data};
          if ((len_d == 16'h0000) || ({1'b0, len_d} > MaxLen)) begin
            state_d      = StError;
            load_error_d = 1'b1;
          end else begin
            state_d = StDataHi;
          end
        end
        StDataHi: begin
          hi_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = StDataLo;
        end
        StDataLo: begin
          csum_d      = csum_q ^ rx_data;
          rom_we_d    = 1'b1;
          rom_wdata_d = {hi_q, rx_data};
          rom_addr_d  = count_q[ADDR_WIDTH-1:0];
          count_d     = count_q + 17'd1;
          state_d     = (count_d == {1'b0, len_q}) ? StCheck : StDataHi;
        end
        StCheck: begin
          if (rx_data == csum_q) begin
            state_d     = StDone;
            load_done_d = 1'b1;
            cpu_rst_d   = 1'b0;
          end else begin
            state_d      = StError;
            load_error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      len_q        <= '0;
      count_q      <= '0;
      csum_q       <= '0;
      hi_q         <= '0;
      rom_we_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_wdata_q  <= '0;
      cpu_rst_q    <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      count_q      <= count_d;
      csum_q       <= csum_d;
      hi_q         <= hi_d;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_wdata_q  <= rom_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: stimulus pushes expected ROM writes, a monitor
// pops and compares them on every rom_we pulse; status flags checked inline.
module tb_boot_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rom_we;
  logic [7:0] rom_addr;
  logic [15:0] rom_wdata;
  logic       cpu_rst;
  logic       load_done;
  logic       load_error;

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_q[$];  // {addr, data}

  boot_loader #(.ADDR_WIDTH(8), .MAGIC(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rom_we     (rom_we),
    .rom_addr   (rom_addr),
    .rom_wdata  (rom_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {8'h0, rom_addr, rom_wdata}, 32'hFFFF_FFFF);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("rom_write", {8'h0, rom_addr, rom_wdata}, {8'h0, e});
      end
    end
  end

  task automatic send(input logic [7:0] b, input int max_gap);
    int tries;
    repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    tries    = 0;
    while (!rx_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!rx_ready) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  // Frame from scenario 1 with a selectable checksum byte.
  task automatic frame1(input logic [7:0] cs, input int max_gap);
    exp_q.push_back({8'h00, 16'h1234});
    exp_q.push_back({8'h01, 16'hABCD});
    send(8'hA5, max_gap);
    chk("err_clear_on_magic", 32'(load_error), 32'd0);
    send(8'h00, max_gap);
    send(8'h02, max_gap);
    send(8'h12, max_gap);
    send(8'h34, max_gap);
    send(8'hAB, max_gap);
    send(8'hCD, max_gap);
    send(cs, max_gap);
  endtask

  task automatic expect_done(input string name);
    chk({name, "_done"}, 32'(load_done), 32'd1);
    chk({name, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    chk({name, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({name, "_error"}, 32'(load_error), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  csum;
    logic [15:0] w;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    chk("rst_rom_we", 32'(rom_we), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rom_wdata", 32'(rom_wdata), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_error", 32'(load_error), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    do_reset();

    // 1: nominal load
    frame1(8'h40, 0);
    expect_done("s1");
    drain("s1_drain");

    // 6: post-done, MAGIC held valid for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      chk("s6_rx_ready", 32'(rx_ready), 32'd0);
      chk("s6_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("s6_done", 32'(load_done), 32'd1);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    drain("s6_drain");

    // 2: bad checksum then retry
    do_reset();
    frame1(8'h41, 0);
    chk("s2_error", 32'(load_error), 32'd1);
    chk("s2_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("s2_done", 32'(load_done), 32'd0);
    drain("s2_bad_drain");
    frame1(8'h40, 0);
    expect_done("s2");
    drain("s2_drain");

    // 3: bad lengths, then full-depth frame
    do_reset();
    send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
    chk("s3_len0_error", 32'(load_error), 32'd1);
    chk("s3_len0_cpu_rst", 32'(cpu_rst), 32'd1);
    send(8'hA5, 0); send(8'h01, 0); send(8'h01, 0);
    chk("s3_len257_error", 32'(load_error), 32'd1);
    drain("s3_badlen_drain");
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0);
    chk("s3_len256_ok", 32'(load_error), 32'd0);
    csum = 8'h00;
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'(i + 1)};
      exp_q.push_back({8'(i), w});
      csum = csum ^ w[15:8] ^ w[7:0];
      send(w[15:8], 0);
      send(w[7:0], 0);
    end
    send(csum, 0);
    expect_done("s3");
    drain("s3_drain");

    // 4: noise and bubbles
    do_reset();
    send(8'h00, 3); send(8'hFF, 3); send(8'h3C, 3);
    chk("s4_noise_idle", {30'h0, load_error, load_done}, 32'd0);
    frame1(8'h40, 3);
    expect_done("s4");
    drain("s4_drain");

    // 5: reset mid-frame
    do_reset();
    send(8'hA5, 0); send(8'h00, 0); send(8'h02, 0); send(8'h12, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("s5_rom_we", 32'(rom_we), 32'd0);
    chk("s5_rom_addr", 32'(rom_addr), 32'd0);
    chk("s5_rom_wdata", 32'(rom_wdata), 32'd0);
    chk("s5_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("s5_flags", {30'h0, load_error, load_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    frame1(8'h40, 0);
    expect_done("s5");
    drain("s5_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Loads a program image into the instruction ROM from a byte stream, then releases the CPU from reset.
- Sits upstream of the Computer. It drives the ROM write port and holds the CPU reset while loading, so benches and boards no longer need to preload ROM contents.
- Frame format: MAGIC, LEN_HI, LEN_LO, then LEN words sent high byte first, then a checksum byte.
- Checksum = XOR of all data bytes.

Parameters:
- ADDR_WIDTH, 8, ROM word-address width; ROM depth = 2^ADDR_WIDTH words.
- MAGIC, 8'hA5, start-of-frame byte.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  incoming stream byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready.
- rom_we  output  1  ROM write strobe, one-cycle pulse per word.
- rom_addr  output  ADDR_WIDTH  ROM write address.
- rom_wdata  output  16  ROM write data.
- cpu_rst  output  1  reset to the Computer; held high until a frame loads successfully.
- load_done  output  1  sticky: a frame loaded and verified.
- load_error  output  1  sticky until the next MAGIC byte or rst: the last frame failed.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rom_we=0, rom_addr=0, rom_wdata=0.
  - cpu_rst=1, load_done=0, load_error=0.
  - Internal length, count, checksum and hi-byte registers cleared.
- rx_ready is combinational from state: 1 in every state except DONE.
- Only accepted bytes (rx_valid && rx_ready) advance the FSM. rx_valid gaps of any length are legal and do not alter the result.
- IDLE:
  - MAGIC -> LEN_HI; clear checksum, rom_addr=0, count=0.
  - Any other byte is discarded.
- LEN_HI: store the byte as len[15:8] -> LEN_LO.
- LEN_LO: store the byte as len[7:0].
  - If len==0 or len>2^ADDR_WIDTH -> ERROR.
  - Otherwise -> DATA_HI.
- DATA_HI: latch the byte as the high byte, XOR it into the checksum -> DATA_LO.
- DATA_LO: XOR the byte into the checksum. On the next edge:
  - rom_wdata={hi,byte}, rom_we=1 for exactly one cycle, rom_addr = current count.
  - count increments.
  - Next state: CHECK if count (after increment) == len, else DATA_HI.
- rom_addr holds each word's address during its rom_we pulse. It advances to count before the next pulse and never wraps inside a frame; the last word of a full-depth frame goes to 2^ADDR_WIDTH-1.
- CHECK: next byte compared with the checksum.
  - Equal -> DONE: load_done=1 and cpu_rst=0, both registered on the same edge that enters DONE.
  - Not equal -> ERROR: load_error=1, cpu_rst stays 1.
- DONE is terminal until rst. rx_ready=0, no further ROM writes, cpu_rst stays 0.
- ERROR:
  - rx_ready=1; non-MAGIC bytes are discarded.
  - MAGIC clears load_error and enters LEN_HI, as from IDLE.
  - ROM words already written by the failed frame are left in place (not cleared).
- cpu_rst=1 in every state other than DONE, so the CPU never runs a partial image.
- rst asserted mid-frame: immediate return to reset values. The partial frame is abandoned, and the next frame starts at address 0.
- A data byte equal to MAGIC inside a frame is ordinary data; there is no resynchronisation mid-frame.

Test Plan:
1. Nominal load: send A5 00 02 12 34 AB CD 40.
   - rom_we pulses twice: addr 0 / 16'h1234, then addr 1 / 16'hABCD.
   - Edge after byte 40: load_done=1, cpu_rst 1->0, rx_ready=0.
2. Checksum failure, then retry: send A5 00 02 12 34 AB CD 41.
   - load_error=1, cpu_rst=1, load_done=0.
   - Then send the frame from scenario 1: load_error clears on A5, load completes, ROM holds 1234/ABCD.
3. Bad lengths:
   - A5 00 00 -> load_error=1 after LEN_LO, no rom_we.
   - With ADDR_WIDTH=8, A5 01 01 -> load_error=1.
   - A5 01 00 (256 words, incrementing data) -> 256 writes, last at addr FF, load_done=1.
4. Noise and bubbles: send 00 FF 3C before the frame from scenario 1, with rx_valid low for 0-3 random cycles between bytes.
   - Noise is ignored; the ROM writes and completion are identical to scenario 1.
5. Reset mid-frame: assert rst for one cycle after A5 00 02 12 has been accepted.
   - All outputs return to their reset values immediately; cpu_rst=1.
   - Frame 1 then loads at addr 0/1 and completes.
6. Post-done: after scenario 1, drive rx_valid=1 with data A5 for 10 cycles.
   - rx_ready stays 0, no rom_we, cpu_rst stays 0, load_done stays 1.
